// File: rtl/if_fetch_pkg.sv
// Shared types for the instruction fetch stage: bus widths, FSM encoding
// and a word-alignment helper used on redirect.
package if_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  typedef logic [InstAddrBus-1:0] inst_addr_t;
  typedef logic [InstBus-1:0]     inst_t;

  typedef enum logic [2:0] {
    IF_IDLE  = 3'd0,
    IF_REQ   = 3'd1,
    IF_WAIT  = 3'd2,
    IF_HOLD  = 3'd3,
    IF_FLUSH = 3'd4
  } if_state_e;

  function automatic inst_addr_t align_word(input inst_addr_t a);
    return {a[InstAddrBus-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_icache.sv
// Direct-mapped instruction cache: tag/data/valid arrays with a combinational hit compare.
// Latency: hit and data are valid in the lookup cycle; writes land on the next edge.
// Backpressure: none; the fetch FSM decides when a lookup is used or a fill is written.
module if_icache
  import if_fetch_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [InstAddrBus-1:0] addr,
  output logic               hit,
  output logic [InstBus-1:0] rd_data,
  input  logic               wr_en,
  input  logic [InstBus-1:0] wr_data
);

  localparam int IW = $clog2(LINES);
  localparam int TW = InstAddrBus - IW - 2;

  logic [TW-1:0]      tag_mem  [LINES];
  logic [InstBus-1:0] data_mem [LINES];
  logic [LINES-1:0]   valid;
  logic [IW-1:0]      idx;
  logic [TW-1:0]      tag;
  logic               unused_addr_lo;

  assign idx            = addr[IW+1:2];
  assign tag            = addr[InstAddrBus-1:IW+2];
  assign hit            = valid[idx] && (tag_mem[idx] == tag);
  assign rd_data        = data_mem[idx];
  assign unused_addr_lo = ^addr[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[idx] <= 1'b1;
    end
  end

  // Storage arrays carry no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= wr_data;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: assembles little-endian words from a byte-wide memory port; optional ICACHE_EN cache.
// Latency: redirect to inst_valid_o in 9 cycles on a zero-wait miss, 2 cycles on a cache hit.
// Backpressure: stall_i holds the output register; a finished word parks in HOLD until it drains.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          ICACHE_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_valid_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  if_state_e  state, state_d;
  inst_addr_t fpc, fpc_d, pc_d;
  inst_t      word, word_d, inst_d, full_word, hit_data;
  logic [1:0] cnt, cnt_d;
  logic       vld_d, slot_free, hit, cache_wr;

  assign slot_free = !inst_valid_o || !stall_i;
  assign full_word = {mem_data_i, word[23:0]};

`ifdef ICACHE_EN
  if_icache #(.LINES(ICACHE_LINES)) u_icache (
    .clk     (clk),
    .rst     (rst),
    .addr    (fpc),
    .hit     (hit),
    .rd_data (hit_data),
    .wr_en   (cache_wr),
    .wr_data (full_word)
  );
`else
  logic unused_cache;
  assign hit          = 1'b0;
  assign hit_data     = '0;
  assign unused_cache = ^{cache_wr, ICACHE_LINES[0]};
`endif

  assign mem_addr_o = mem_req_o ? (fpc + {30'd0, cnt}) : '0;

  always_comb begin
    state_d   = state;
    fpc_d     = fpc;
    cnt_d     = cnt;
    word_d    = word;
    pc_d      = pc_o;
    inst_d    = inst_o;
    vld_d     = inst_valid_o;
    cache_wr  = 1'b0;
    mem_req_o = 1'b0;

    if (inst_valid_o && !stall_i) vld_d = 1'b0;

    case (state)
      IF_IDLE: state_d = IF_REQ;
      IF_REQ: begin
        if (cnt == 2'd0 && hit) begin
          if (slot_free) begin
            pc_d   = fpc;
            inst_d = hit_data;
            vld_d  = 1'b1;
            fpc_d  = fpc + 32'd4;
          end else begin
            word_d  = hit_data;
            state_d = IF_HOLD;
          end
        end else begin
          mem_req_o = 1'b1;
          if (mem_gnt_i) state_d = IF_WAIT;
        end
      end
      IF_WAIT: begin
        if (mem_valid_i) begin
          if (cnt != 2'd3) begin
            word_d[{cnt, 3'b000} +: 8] = mem_data_i;
            cnt_d   = cnt + 2'd1;
            state_d = IF_REQ;
          end else begin
            cache_wr = 1'b1;
            cnt_d    = 2'd0;
            if (slot_free) begin
              pc_d    = fpc;
              inst_d  = full_word;
              vld_d   = 1'b1;
              fpc_d   = fpc + 32'd4;
              state_d = IF_REQ;
            end else begin
              word_d  = full_word;
              state_d = IF_HOLD;
            end
          end
        end
      end
      IF_HOLD: begin
        if (slot_free) begin
          pc_d    = fpc;
          inst_d  = word;
          vld_d   = 1'b1;
          fpc_d   = fpc + 32'd4;
          state_d = IF_REQ;
        end
      end
      IF_FLUSH: if (mem_valid_i) state_d = IF_REQ;
      default:  state_d = IF_IDLE;
    endcase

    // Redirect wins over everything. Only flush when a byte is still owed to us:
    // a byte arriving in this very cycle has already closed the transaction.
    if (branch_taken_i) begin
      fpc_d    = align_word(branch_target_i);
      cnt_d    = 2'd0;
      vld_d    = 1'b0;
      cache_wr = 1'b0;
      if ((mem_req_o && mem_gnt_i) ||
          ((state == IF_WAIT || state == IF_FLUSH) && !mem_valid_i))
        state_d = IF_FLUSH;
      else
        state_d = IF_REQ;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IF_IDLE;
      fpc          <= RESET_PC;
      cnt          <= 2'd0;
      word         <= '0;
      pc_o         <= '0;
      inst_o       <= '0;
      inst_valid_o <= 1'b0;
    end else begin
      state        <= state_d;
      fpc          <= fpc_d;
      cnt          <= cnt_d;
      word         <= word_d;
      pc_o         <= pc_d;
      inst_o       <= inst_d;
      inst_valid_o <= vld_d;
    end
  end

endmodule
